// File: rtl/game_spawn_pkg.sv
// Shared types and constants for the target spawn scheduler and its LFSR.
package game_spawn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        WRITE,
        DONE
    } spawn_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int unsigned VEL_W     = 4;
    localparam int unsigned LEVEL_W   = 3;

    // One step of the right-shifting Galois LFSR; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/game_lfsr16.sv
// Free-running 16-bit Galois LFSR; also reused for bullet jitter.
module game_lfsr16
    import game_spawn_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next state: advance one step when enabled.
    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = lfsr_next(q_q);
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/game_target_spawn_scheduler.sv
// Spawns N target sprites per round: draws position/speed from the LFSR and
// writes each target in turn, then signals completion to the master FSM.
module game_target_spawn_scheduler
    import game_spawn_pkg::*;
#(
    parameter int unsigned    N_TARGETS = 3,
    parameter int unsigned    X_WIDTH   = 10,
    parameter int unsigned    Y_WIDTH   = 10,
    parameter int unsigned    X_MIN     = 64,
    parameter int unsigned    MAX_LEVEL = 6,
    parameter logic [15:0]    LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      round_start,
    input  logic [3:0]                score,
    output logic                      spawn_busy,
    output logic                      spawn_done,
    output logic [N_TARGETS-1:0]      write_xy,
    output logic [N_TARGETS-1:0]      write_dxy,
    output logic [X_WIDTH-1:0]        x,
    output logic [Y_WIDTH-1:0]        y,
    output logic signed [VEL_W-1:0]   dx,
    output logic signed [VEL_W-1:0]   dy,
    output logic [LEVEL_W-1:0]        level
);

    spawn_state_t                state_q, state_d;
    logic [2:0]                  idx_q, idx_d;
    logic [LEVEL_W-1:0]          level_q, level_d;
    logic [X_WIDTH-1:0]          x_q, x_d;
    logic [Y_WIDTH-1:0]          y_q, y_d;
    logic signed [VEL_W-1:0]     dx_q, dx_d;
    logic signed [VEL_W-1:0]     dy_q, dy_d;
    logic [N_TARGETS-1:0]        wr_q, wr_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;

    logic [15:0]                 lfsr;
    logic [3:0]                  level_raw;
    logic [VEL_W-1:0]            speed;

    game_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (1'b1),
        .q      (lfsr)
    );

    assign level_raw = score >> 1;
    assign speed     = VEL_W'(level_q) + VEL_W'(1);

    // Next-state and next-output logic; strobes and done default low so they pulse for one cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        level_d = level_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        wr_d    = '0;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (round_start) begin
                    state_d = DRAW;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    level_d = (level_raw > 4'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                          : level_raw[LEVEL_W-1:0];
                end
            end
            DRAW: begin
                x_d     = X_WIDTH'(X_MIN) + X_WIDTH'(lfsr[8:0]);
                y_d     = Y_WIDTH'(lfsr[15:9]);
                dx_d    = lfsr[0] ? $signed(-speed) : $signed(speed);
                dy_d    = VEL_W'(1);
                wr_d    = N_TARGETS'(1) << idx_q;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == 3'(N_TARGETS - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = DRAW;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any spawn in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            level_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            wr_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign spawn_busy = busy_q;
    assign spawn_done = done_q;
    assign write_xy   = wr_q;
    assign write_dxy  = wr_q;
    assign x          = x_q;
    assign y          = y_q;
    assign dx         = dx_q;
    assign dy         = dy_q;
    assign level      = level_q;

endmodule
